// File: rtl/pwm_level_ctrl.sv
// Brightness control: debounced up/down buttons step a saturating level 0..MAX_LVL with auto-repeat, shown in decimal.
// Latency: w moves on the 2^DB_N+4-th edge after a press is first sampled; repeats every 2^RPT_N cycles while held.
// Backpressure: none; buttons are sampled every cycle and the multiplexer inputs are plain registered levels.
module pwm_level_ctrl #(
  parameter int DB_N     = 20,
  parameter int RPT_N    = 24,
  parameter int MAX_LVL  = 10,
  parameter int INIT_LVL = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic [3:0] w,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dp_in
);

  // Level limits and the display image of the reset level.
  localparam logic [3:0] MAX_W     = 4'(MAX_LVL);
  localparam logic [3:0] INIT_W    = 4'(INIT_LVL);
  localparam logic [3:0] INIT_HEX1 = (INIT_LVL >= 10) ? 4'd1 : 4'd0;
  localparam logic [3:0] INIT_HEX0 = (INIT_LVL >= 10) ? 4'(INIT_LVL - 10) : 4'(INIT_LVL);
  localparam logic       INIT_DP0  = !((INIT_LVL == 0) || (INIT_LVL == MAX_LVL));

  // Index 0 is the up button, index 1 the down button.
  logic [1:0] btn_raw;
  logic [1:0] tick;

  assign btn_raw = {btn_dn, btn_up};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;

    db_state_t        state;
    db_state_t        state_nxt;
    logic             sync0;
    logic             s;
    logic [DB_N-1:0]  cnt;
    logic [RPT_N-1:0] rpt;
    logic             cnt_max;
    logic             rpt_max;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             rpt_clr;
    logic             rpt_inc;
    logic             tick_nxt;

    assign cnt_max = (cnt == {DB_N{1'b1}});
    assign rpt_max = (rpt == {RPT_N{1'b1}});

    // Two-flop synchronizer; only the second stage is seen by the debouncer.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync0 <= 1'b0;
        s     <= 1'b0;
      end else begin
        sync0 <= btn_raw[b];
        s     <= sync0;
      end
    end

    // Debounce state register.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= ZERO;
      end else begin
        state <= state_nxt;
      end
    end

    // Next state: a level must persist a full counter span before it is accepted.
    always_comb begin
      state_nxt = state;
      case (state)
        ZERO: begin
          if (s) state_nxt = WAIT1;
        end
        WAIT1: begin
          if (!s)          state_nxt = ZERO;
          else if (cnt_max) state_nxt = ONE;
        end
        ONE: begin
          if (!s) state_nxt = WAIT0;
        end
        WAIT0: begin
          if (s)            state_nxt = ONE;
          else if (cnt_max) state_nxt = ZERO;
        end
        default: state_nxt = ZERO;
      endcase
    end

    // Counter controls and tick request; a bounce back to ONE leaves the repeat phase untouched.
    always_comb begin
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      rpt_clr  = 1'b0;
      rpt_inc  = 1'b0;
      tick_nxt = 1'b0;
      case (state)
        ZERO: begin
          cnt_clr = s;
        end
        WAIT1: begin
          if (s) begin
            if (cnt_max) begin
              rpt_clr  = 1'b1;
              tick_nxt = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        ONE: begin
          if (s) begin
            rpt_inc  = 1'b1;
            tick_nxt = rpt_max;
          end else begin
            cnt_clr = 1'b1;
          end
        end
        WAIT0: begin
          if (!s && !cnt_max) cnt_inc = 1'b1;
        end
        default: begin
          cnt_clr = 1'b1;
        end
      endcase
    end

    // Debounce and repeat counters plus the one-cycle tick register; rpt wraps to 0 after its tick.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt  <= '0;
        rpt  <= '0;
        tick[b] <= 1'b0;
      end else begin
        if (cnt_clr)      cnt <= '0;
        else if (cnt_inc) cnt <= cnt + DB_N'(1);
        if (rpt_clr)      rpt <= '0;
        else if (rpt_inc) rpt <= rpt + RPT_N'(1);
        tick[b] <= tick_nxt;
      end
    end
  end

  logic [3:0] w_nxt;
  logic [3:0] hex1_nxt;
  logic [3:0] hex0_nxt;
  logic       dp0_nxt;
  logic       dp0;

  // Saturating step; coincident up and down ticks cancel.
  always_comb begin
    w_nxt = w;
    if (tick[0] && !tick[1]) begin
      if (w < MAX_W) w_nxt = w + 4'd1;
    end else if (tick[1] && !tick[0]) begin
      if (w != 4'd0) w_nxt = w - 4'd1;
    end
  end

  // Decimal split of the new level and the limit marker on the rightmost point.
  always_comb begin
    hex1_nxt = (w_nxt >= 4'd10) ? 4'd1 : 4'd0;
    hex0_nxt = (w_nxt >= 4'd10) ? (w_nxt - 4'd10) : w_nxt;
    dp0_nxt  = !((w_nxt == 4'd0) || (w_nxt == MAX_W));
  end

  // Level and display registers share one edge so the readout never lags the duty value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w    <= INIT_W;
      hex1 <= INIT_HEX1;
      hex0 <= INIT_HEX0;
      dp0  <= INIT_DP0;
    end else begin
      w    <= w_nxt;
      hex1 <= hex1_nxt;
      hex0 <= hex0_nxt;
      dp0  <= dp0_nxt;
    end
  end

  assign hex3  = 4'd0;
  assign hex2  = 4'd0;
  assign dp_in = {3'b111, dp0};

endmodule

// File: tb/tb_pwm_level_ctrl.sv
// Bench for pwm_level_ctrl with short debounce/repeat spans.
// Latency: expected output changes are queued with their cycle and matched as they appear.
// Backpressure: none; buttons are driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_pwm_level_ctrl;

  localparam int DB_N     = 3;
  localparam int RPT_N    = 5;
  localparam int MAX_LVL  = 10;
  localparam int INIT_LVL = 5;
  localparam int LAT      = (1 << DB_N) + 4;  // edges from first sample to w change
  localparam int TICK_OFS = (1 << DB_N) + 1;  // held cycles needed for the first tick
  localparam int RPT      = 1 << RPT_N;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic [3:0] w, hex3, hex2, hex1, hex0, dp_in;

  pwm_level_ctrl #(
    .DB_N(DB_N), .RPT_N(RPT_N), .MAX_LVL(MAX_LVL), .INIT_LVL(INIT_LVL)
  ) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn),
    .w(w), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0), .dp_in(dp_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [3:0] lvl;
  } ev_t;
  ev_t sbq[$];

  typedef struct {
    string      name;
    logic       up;
    logic       dn;
    int         hold;
    logic [3:0] exp_w;
  } vec_t;
  vec_t vecs[14];

  int mw = INIT_LVL;

  // Scoreboard monitor: every change of the output vector must match the queue head.
  logic        mon_en = 1'b0;
  logic [23:0] prev_out;
  ev_t         mon_e;
  always @(posedge clk) begin
    #1;
    if (mon_en && ({w, hex3, hex2, hex1, hex0, dp_in} !== prev_out)) begin
      prev_out = {w, hex3, hex2, hex1, hex0, dp_in};
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_change: w=%0d dp_in=%b at cycle %0d, no change expected", w, dp_in, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("ev_cycle", cyc, mon_e.cyc);
        chk("ev_w", int'(w), int'(mon_e.lvl));
        chk("ev_hex1", int'(hex1), (mon_e.lvl >= 10) ? 1 : 0);
        chk("ev_hex0", int'(hex0), int'(mon_e.lvl) % 10);
        chk("ev_dp_in", int'(dp_in), (mon_e.lvl == 0 || mon_e.lvl == MAX_LVL) ? 14 : 15);
        chk("ev_hex3_hex2", int'({hex3, hex2}), 0);
      end
    end
  end

  function automatic void push_ev(input int at, input int lvl);
    ev_t e;
    e.cyc = at;
    e.lvl = 4'(lvl);
    sbq.push_back(e);
  endfunction

  // Press pattern from a falling edge; queues the level steps the press should cause.
  task automatic press(input logic up, input logic dn, input int hold, input int gap);
    int k;
    int nw;
    k = cyc;
    btn_up = up;
    btn_dn = dn;
    for (int m = 0; TICK_OFS + RPT * m <= hold; m++) begin
      nw = mw;
      if (up && !dn && mw < MAX_LVL) nw = mw + 1;
      else if (dn && !up && mw > 0)  nw = mw - 1;
      if (nw != mw) push_ev(k + LAT + RPT * m, nw);
      mw = nw;
    end
    repeat (hold) @(negedge clk);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_row(input int i);
    press(vecs[i].up, vecs[i].dn, vecs[i].hold, 20);
    chk(vecs[i].name, int'(w), int'(vecs[i].exp_w));
  endtask

  initial begin
    int k;
    int r;

    vecs[0]  = '{"idle_50",       1'b0, 1'b0, 50,  4'd5};
    vecs[1]  = '{"up_20",         1'b1, 1'b0, 20,  4'd6};
    vecs[2]  = '{"dn_20",         1'b0, 1'b1, 20,  4'd5};
    vecs[3]  = '{"up_too_short",  1'b1, 1'b0, 8,   4'd5};
    vecs[4]  = '{"up_just_long",  1'b1, 1'b0, 9,   4'd6};
    vecs[5]  = '{"dn_just_long",  1'b0, 1'b1, 9,   4'd5};
    vecs[6]  = '{"up_hold_to_max",1'b1, 1'b0, 180, 4'd10};
    vecs[7]  = '{"up_at_max",     1'b1, 1'b0, 60,  4'd10};
    vecs[8]  = '{"dn_hold_to_2",  1'b0, 1'b1, 240, 4'd2};
    vecs[9]  = '{"dn_hold_to_0",  1'b0, 1'b1, 100, 4'd0};
    vecs[10] = '{"up_two_steps",  1'b1, 1'b0, 50,  4'd2};
    vecs[11] = '{"both_one_tick", 1'b1, 1'b1, 12,  4'd2};
    vecs[12] = '{"both_two_ticks",1'b1, 1'b1, 45,  4'd2};
    vecs[13] = '{"up_hold_to_8",  1'b1, 1'b0, 200, 4'd8};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_w", int'(w), INIT_LVL);
    chk("rst_hex1", int'(hex1), 0);
    chk("rst_hex0", int'(hex0), 5);
    chk("rst_hex3_hex2", int'({hex3, hex2}), 0);
    chk("rst_dp_in", int'(dp_in), 15);
    reset = 1'b0;
    prev_out = {w, hex3, hex2, hex1, hex0, dp_in};
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) run_row(i);

    // Bounce shorter than the debounce span: no step, then a clean press must see full latency.
    btn_up = 1'b1; repeat (4) @(negedge clk);
    btn_up = 1'b0; repeat (2) @(negedge clk);
    btn_up = 1'b1; repeat (5) @(negedge clk);
    btn_up = 1'b0; repeat (20) @(negedge clk);
    chk("bounce_w", int'(w), 5);
    press(1'b1, 1'b0, 20, 20);
    chk("after_bounce_up", int'(w), 6);
    press(1'b0, 1'b1, 20, 20);
    chk("after_bounce_dn", int'(w), 5);

    for (int i = 6; i < 14; i++) run_row(i);

    // Reset while the up debouncer is mid-count and w=8, button still held through release.
    k = cyc;
    btn_up = 1'b1;
    repeat (8) @(negedge clk);
    push_ev(cyc + 1, INIT_LVL);
    mw = INIT_LVL;
    reset = 1'b1;
    #1;
    chk("mid_rst_w_async", int'(w), INIT_LVL);
    chk("mid_rst_dp_in", int'(dp_in), 15);
    repeat (3) @(negedge clk);
    r = cyc;
    push_ev(r + LAT, INIT_LVL + 1);
    mw = INIT_LVL + 1;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    btn_up = 1'b0;
    repeat (20) @(negedge clk);
    chk("re_debounce_w", int'(w), INIT_LVL + 1);
    chk("re_debounce_start", k + 8 + 3, r);

    repeat (40) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
